// File: rtl/stg5wb_pkg.sv
// Shared sizes, opcode constants and state type for the write-back stage.
// Opcode lives in instr[HBIT_DATA -: 8]; destination rd in the next 4 bits down.
package stg5wb_pkg;
    localparam int SIZE_ADDR = 16;
    localparam int SIZE_DATA = 16;
    localparam int HBIT_ADDR = SIZE_ADDR - 1;
    localparam int HBIT_DATA = SIZE_DATA - 1;
    localparam int IDX_W     = 4;

    localparam logic [7:0] OPC_NOP     = 8'h00;
    localparam logic [7:0] OPC_ALU_ADD = 8'h10;
    localparam logic [7:0] OPC_ALU_SUB = 8'h11;
    localparam logic [7:0] OPC_ALU_AND = 8'h12;
    localparam logic [7:0] OPC_ALU_OR  = 8'h13;
    localparam logic [7:0] OPC_LD      = 8'h20;
    localparam logic [7:0] OPC_ST      = 8'h21;
    localparam logic [7:0] OPC_MOV     = 8'h30;
    localparam logic [7:0] OPC_HLT     = 8'hFF;

    typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

    // Opcodes that produce a register result.
    function automatic logic is_write_op(input logic [7:0] opc);
        return (opc == OPC_ALU_ADD) || (opc == OPC_ALU_SUB) ||
               (opc == OPC_ALU_AND) || (opc == OPC_ALU_OR)  ||
               (opc == OPC_LD)      || (opc == OPC_MOV);
    endfunction
endpackage

// File: rtl/stg5wb_regfile.sv
// Register file: two combinational read ports, one synchronous write port.
// r0 is hard-wired to zero; indices beyond REG_COUNT read zero.
module stg5wb_regfile
    import stg5wb_pkg::*;
#(
    parameter int REG_COUNT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wen,
    input  logic [IDX_W-1:0]     wr_idx,
    input  logic [SIZE_DATA-1:0] wr_data,
    input  logic [IDX_W-1:0]     rd_a,
    input  logic [IDX_W-1:0]     rd_b,
    output logic [SIZE_DATA-1:0] rd_a_data,
    output logic [SIZE_DATA-1:0] rd_b_data
);
    logic [SIZE_DATA-1:0] mem [REG_COUNT];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < REG_COUNT; i++) mem[i] <= '0;
        end else if (wen && wr_idx != '0 && int'(wr_idx) < REG_COUNT) begin
            mem[wr_idx] <= wr_data;
        end
    end

    always_comb begin
        rd_a_data = '0;
        rd_b_data = '0;
        if (rd_a != '0 && int'(rd_a) < REG_COUNT) rd_a_data = mem[rd_a];
        if (rd_b != '0 && int'(rd_b) < REG_COUNT) rd_b_data = mem[rd_b];
    end
endmodule

// File: rtl/stg5wb.sv
// Write-back stage: RUN/HALT FSM, register write, retire tracking.
// Define STG5WB_BYPASS_EN for same-cycle write-through on the read ports.
module stg5wb
    import stg5wb_pkg::*;
#(
    parameter int REG_COUNT = 16,
    parameter int RETIRE_W  = 16
) (
    input  logic                 iw_clk,
    input  logic                 iw_rst,
    input  logic [SIZE_ADDR-1:0] iw_pc,
    input  logic [SIZE_DATA-1:0] iw_instr,
    input  logic [SIZE_DATA-1:0] iw_result,
    input  logic                 iw_valid,
    input  logic [IDX_W-1:0]     iw_rd_a,
    input  logic [IDX_W-1:0]     iw_rd_b,
    output logic [SIZE_DATA-1:0] ow_rd_a_data,
    output logic [SIZE_DATA-1:0] ow_rd_b_data,
    output logic [SIZE_ADDR-1:0] ow_pc,
    output logic [SIZE_DATA-1:0] ow_instr,
    output logic [RETIRE_W-1:0]  ow_retire_cnt,
    output logic                 ow_halt
);
    state_t           state, state_nxt;
    logic [7:0]       opcode;
    logic [IDX_W-1:0] rd;
    logic             retire, wen;
    logic [SIZE_DATA-1:0] rf_a, rf_b;

    assign opcode = iw_instr[HBIT_DATA -: 8];
    assign rd     = iw_instr[HBIT_DATA-8 -: IDX_W];
    assign retire = (state == RUN) && iw_valid;
    assign wen    = retire && is_write_op(opcode) && (rd != '0);

    always_ff @(posedge iw_clk) begin
        if (!iw_rst) state <= RUN;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (state == RUN && iw_valid && opcode == OPC_HLT) state_nxt = HALT;
    end

    assign ow_halt = (state == HALT);

    always_ff @(posedge iw_clk) begin
        if (!iw_rst) begin
            ow_pc         <= '0;
            ow_instr      <= '0;
            ow_retire_cnt <= '0;
        end else if (retire) begin
            ow_pc         <= iw_pc;
            ow_instr      <= iw_instr;
            ow_retire_cnt <= ow_retire_cnt + 1'b1;
        end
    end

    stg5wb_regfile #(.REG_COUNT(REG_COUNT)) u_rf (
        .clk       (iw_clk),
        .rst       (iw_rst),
        .wen       (wen),
        .wr_idx    (rd),
        .wr_data   (iw_result),
        .rd_a      (iw_rd_a),
        .rd_b      (iw_rd_b),
        .rd_a_data (rf_a),
        .rd_b_data (rf_b)
    );

`ifdef STG5WB_BYPASS_EN
    // wen already excludes rd==0, so r0 stays zero through the bypass.
    assign ow_rd_a_data = (wen && iw_rd_a == rd) ? iw_result : rf_a;
    assign ow_rd_b_data = (wen && iw_rd_b == rd) ? iw_result : rf_b;
`else
    assign ow_rd_a_data = rf_a;
    assign ow_rd_b_data = rf_b;
`endif
endmodule

// File: tb/tb_stg5wb.sv
// Directed bench for stg5wb; a narrow retire counter keeps the wrap test short.
module tb_stg5wb;
    import stg5wb_pkg::*;

    localparam int RW = 6;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [SIZE_ADDR-1:0] pc;
    logic [SIZE_DATA-1:0] instr, result;
    logic                 valid;
    logic [3:0]           rd_a, rd_b;
    logic [SIZE_DATA-1:0] rd_a_data, rd_b_data;
    logic [SIZE_ADDR-1:0] o_pc;
    logic [SIZE_DATA-1:0] o_instr;
    logic [RW-1:0]        cnt;
    logic                 halt;

    int vectors = 0;
    int miscompares = 0;

    stg5wb #(.REG_COUNT(16), .RETIRE_W(RW)) dut (
        .iw_clk(clk), .iw_rst(rst), .iw_pc(pc), .iw_instr(instr),
        .iw_result(result), .iw_valid(valid), .iw_rd_a(rd_a), .iw_rd_b(rd_b),
        .ow_rd_a_data(rd_a_data), .ow_rd_b_data(rd_b_data), .ow_pc(o_pc),
        .ow_instr(o_instr), .ow_retire_cnt(cnt), .ow_halt(halt)
    );

    always #5 clk = ~clk;

`ifdef STG5WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    function automatic logic [15:0] mk(input logic [7:0] op, input logic [3:0] r);
        return {op, r, 4'h0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] op, input logic [3:0] r,
                         input logic [15:0] res, input logic [15:0] p);
        valid = v; instr = mk(op, r); result = res; pc = p;
    endtask

    // Advance one edge and settle past it.
    task automatic tick();
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b0; valid = 1'b0; pc = '0; instr = '0; result = '0; rd_a = '0; rd_b = '0;
        // Reset with a live write presented: it must be discarded.
        drive(1'b1, OPC_MOV, 4'd9, 16'hDEAD, 16'h0F00);
        tick(); tick();
        rst = 1'b1;
        drive(1'b0, OPC_NOP, 4'd0, 16'h0, 16'h0);
        #1;
        chk("rst_halt", halt, 0);
        chk("rst_cnt", cnt, 0);
        chk("rst_pc", o_pc, 0);
        chk("rst_instr", o_instr, 0);
        for (int i = 0; i < 16; i++) begin
            rd_a = 4'(i); rd_b = 4'(15 - i); #1;
            chk($sformatf("rst_ra_r%0d", i), rd_a_data, 0);
            chk($sformatf("rst_rb_r%0d", 15 - i), rd_b_data, 0);
        end

        // MOV r3 = 00A5
        rd_a = 4'd3; rd_b = 4'd0;
        drive(1'b1, OPC_MOV, 4'd3, 16'h00A5, 16'h0100); #1;
        chk("mov_pre_ra", rd_a_data, BYP ? 32'h00A5 : 32'h0);
        chk("mov_pre_rb_r0", rd_b_data, 0);
        tick();
        drive(1'b0, OPC_NOP, 4'd0, 16'h0, 16'h0); #1;
        chk("mov_r3", rd_a_data, 16'h00A5);
        chk("mov_cnt", cnt, 1);
        chk("mov_pc", o_pc, 16'h0100);
        chk("mov_instr", o_instr, 16'h3030);

        // ALU r5 = 1234, then r5 = 5678 with both ports on r5
        rd_a = 4'd5; rd_b = 4'd5;
        drive(1'b1, OPC_ALU_ADD, 4'd5, 16'h1234, 16'h0104); #1;
        chk("alu5_pre_rb", rd_b_data, BYP ? 32'h1234 : 32'h0);
        tick();
        drive(1'b1, OPC_ALU_SUB, 4'd5, 16'h5678, 16'h0108); #1;
        chk("alu5b_pre_ra", rd_a_data, BYP ? 32'h5678 : 32'h1234);
        chk("alu5b_pre_rb", rd_b_data, BYP ? 32'h5678 : 32'h1234);
        tick();
        drive(1'b0, OPC_NOP, 4'd0, 16'h0, 16'h0); #1;
        chk("alu5_post", rd_b_data, 16'h5678);
        chk("alu5_cnt", cnt, 3);

        // Bubble carrying a write-class instruction: no write, no retire
        rd_a = 4'd6;
        drive(1'b0, OPC_MOV, 4'd6, 16'hBEEF, 16'h0200); #1;
        chk("bub_pre_r6", rd_a_data, 0);
        tick();
        chk("bub_r6", rd_a_data, 0);
        chk("bub_cnt", cnt, 3);
        chk("bub_pc", o_pc, 16'h0108);

        // Store retires but does not write
        rd_a = 4'd7;
        drive(1'b1, OPC_ST, 4'd7, 16'h1111, 16'h0204); tick();
        chk("st_r7", rd_a_data, 0);
        chk("st_cnt", cnt, 4);

        // ALU rd=0: r0 stays zero
        rd_a = 4'd0;
        drive(1'b1, OPC_ALU_OR, 4'd0, 16'hFFFF, 16'h0208); #1;
        chk("r0_pre", rd_a_data, 0);
        tick();
        chk("r0_post", rd_a_data, 0);
        chk("r0_cnt", cnt, 5);

        // LD r15
        rd_b = 4'd15;
        drive(1'b1, OPC_LD, 4'd15, 16'hCAFE, 16'h020C); tick();
        chk("ld_r15", rd_b_data, 16'hCAFE);
        chk("ld_cnt", cnt, 6);

        // HLT retires and halts
        drive(1'b1, OPC_HLT, 4'd0, 16'h0, 16'h0300); #1;
        chk("hlt_pre_halt", halt, 0);
        tick();
        chk("hlt_halt", halt, 1);
        chk("hlt_cnt", cnt, 7);
        chk("hlt_pc", o_pc, 16'h0300);
        chk("hlt_instr", o_instr, 16'hFF00);

        // MOV while halted: ignored
        rd_a = 4'd2;
        drive(1'b1, OPC_MOV, 4'd2, 16'h0007, 16'h0304); #1;
        chk("halt_pre_r2", rd_a_data, 0);
        tick();
        chk("halt_r2", rd_a_data, 0);
        chk("halt_cnt", cnt, 7);
        chk("halt_pc", o_pc, 16'h0300);
        chk("halt_still", halt, 1);

        // One reset cycle with a live MOV: reset wins
        rst = 1'b0; rd_a = 4'd4; rd_b = 4'd3;
        drive(1'b1, OPC_MOV, 4'd4, 16'h0009, 16'h0400);
        tick();
        rst = 1'b1;
        drive(1'b0, OPC_NOP, 4'd0, 16'h0, 16'h0); #1;
        chk("rst2_halt", halt, 0);
        chk("rst2_cnt", cnt, 0);
        chk("rst2_r4", rd_a_data, 0);
        chk("rst2_r3", rd_b_data, 0);
        chk("rst2_pc", o_pc, 0);

        // Fill the counter to all-ones with bubbles interleaved
        for (int i = 0; i < (1 << RW) - 1; i++) begin
            drive(1'b1, OPC_NOP, 4'd0, 16'h0, 16'(16'h1000 + i)); tick();
            if (i % 3 == 0) begin
                drive(1'b0, OPC_NOP, 4'd0, 16'h0, 16'h7777); tick();
            end
        end
        chk("wrap_full", cnt, (1 << RW) - 1);
        chk("wrap_pc_last", o_pc, 16'h1000 + (1 << RW) - 2);
        drive(1'b1, OPC_NOP, 4'd0, 16'h0, 16'h2000); tick();
        chk("wrap_zero", cnt, 0);
        chk("wrap_pc", o_pc, 16'h2000);
        drive(1'b0, OPC_NOP, 4'd0, 16'h0, 16'h0); tick();
        chk("wrap_bubble", cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
